// File: rtl/matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scanner
//  Description : Strobes an 8x8 key matrix one row at a time, samples the
//                active-low column sense lines, debounces each row and emits
//                changed rows as cell-memory writes over a req/ack handshake.
//                Optional build macro MATRIX_SCANNER_TOGGLE_EN selects toggle
//                mode (each debounced press flips the cell) instead of level
//                mode (committed row follows the debounced key level).
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_scanner #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic       scan_en,
    output logic [7:0] row_drv,
    input  logic [7:0] col_sense,
    output logic       wr_req,
    input  logic       wr_ack,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_MAX     = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EVAL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            advance;

    logic [2:0]      row;
    logic [SW-1:0]   settle;
    logic [7:0]      sample;
    logic [7:0]      last_q    [8];
    logic [CW-1:0]   cnt_q     [8];
    logic [7:0]      committed [8];

    logic [CW-1:0]   cnt_upd;
    logic            stable;
    logic            do_write;
    logic [7:0]      commit_upd;
`ifdef MATRIX_SCANNER_TOGGLE_EN
    logic [7:0]      deb [8];
    logic [7:0]      rise;
    logic            deb_change;
`endif

    // Debounce evaluation for the current row; the new sample always becomes
    // last[row], only the run-length counter depends on whether it repeated.
    always_comb begin
        if (sample != last_q[row])
            cnt_upd = CW'(1);
        else if (cnt_q[row] == DEB_MAX)
            cnt_upd = DEB_MAX;
        else
            cnt_upd = cnt_q[row] + CW'(1);
        stable = (cnt_upd == DEB_MAX);
`ifdef MATRIX_SCANNER_TOGGLE_EN
        deb_change = stable && (sample != deb[row]);
        rise       = sample & ~deb[row];
        do_write   = deb_change && (rise != 8'h00);
        commit_upd = committed[row] ^ rise;
`else
        do_write   = stable && (sample != committed[row]);
        commit_upd = sample;
`endif
    end

    // State register; leaving reset always restarts from IDLE.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and row strobe; row_drv is low outside DRIVE so adjacent
    // rows never overlap.
    always_comb begin
        state_nxt = state;
        row_drv   = 8'h00;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (scan_en)
                    state_nxt = DRIVE;
            end
            DRIVE: begin
                row_drv = 8'h01 << row;
                if (settle == SETTLE_LAST)
                    state_nxt = EVAL;
            end
            EVAL: begin
                if (do_write)
                    state_nxt = WRITE;
                else
                    advance = 1'b1;
            end
            WRITE: begin
                if (wr_ack)
                    advance = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (advance)
            state_nxt = scan_en ? DRIVE : IDLE;
    end

    // Datapath: settle timer, sample capture, per-row debounce state,
    // write handshake registers, row pointer and frame pulse.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            row        <= 3'd0;
            settle     <= '0;
            sample     <= 8'h00;
            wr_req     <= 1'b0;
            wr_addr    <= 3'd0;
            wr_data    <= 8'h00;
            frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                last_q[i]    <= 8'h00;
                cnt_q[i]     <= '0;
                committed[i] <= 8'h00;
`ifdef MATRIX_SCANNER_TOGGLE_EN
                deb[i]       <= 8'h00;
`endif
            end
        end else begin
            frame_done <= 1'b0;
            if (state == DRIVE) begin
                if (settle == SETTLE_LAST) begin
                    settle <= '0;
                    sample <= ~col_sense;
                end else begin
                    settle <= settle + SW'(1);
                end
            end
            if (state == EVAL) begin
                last_q[row] <= sample;
                cnt_q[row]  <= cnt_upd;
`ifdef MATRIX_SCANNER_TOGGLE_EN
                if (deb_change)
                    deb[row] <= sample;
`endif
                if (do_write) begin
                    committed[row] <= commit_upd;
                    wr_req         <= 1'b1;
                    wr_addr        <= row;
                    wr_data        <= commit_upd;
                end
            end
            if (state == WRITE && wr_ack)
                wr_req <= 1'b0;
            if (advance) begin
                row        <= row + 3'd1;
                frame_done <= (row == 3'd7);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_scanner
//  Description : Self-checking bench for matrix_scanner. A key-matrix model
//                drives col_sense from row_drv; expected row writes are
//                queued when keys change and compared when the DUT's write
//                handshake completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scanner;

`ifdef MATRIX_SCANNER_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    logic       ph1     = 1'b0;
    logic       reset   = 1'b0;
    logic       scan_en = 1'b1;
    logic       wr_ack  = 1'b1;
    logic [7:0] row_drv;
    logic [7:0] col_sense;
    logic       wr_req;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;

    logic [7:0] keys [8];

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         stamp;
        bit         lat;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   frames = 0;

    matrix_scanner #(
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .ph1        (ph1),
        .reset      (reset),
        .scan_en    (scan_en),
        .row_drv    (row_drv),
        .col_sense  (col_sense),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done)
    );

    // Clock
    always #5 ph1 = ~ph1;

    // Key matrix: a pressed key pulls its column low while its row is strobed
    always_comb begin
        col_sense = 8'hFF;
        for (int r = 0; r < 8; r++)
            if (row_drv[r])
                col_sense = col_sense & ~keys[r];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: frame counter and write-handshake completion
    always @(negedge ph1) begin
        exp_t e;
        if (frame_done)
            frames = frames + 1;
        if (reset && wr_req && wr_ack) begin
            if (q.size() == 0) begin
                check("unexpected_wr", {21'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                if (e.lat)
                    check("wr_latency_frames", 32'(frames - e.stamp), 32'd3);
            end
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge ph1);
            n++;
        end while (!frame_done && n < 200);
        check("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_wr_req();
        int n = 0;
        do begin
            @(negedge ph1);
            n++;
        end while (!wr_req && n < 300);
        check("wr_req_seen", 32'(wr_req), 32'd1);
    endtask

    task automatic wait_row(input logic [7:0] exp_row);
        int n = 0;
        do begin
            @(negedge ph1);
            n++;
        end while (row_drv == 8'h00 && n < 50);
        check("first_row_drv", 32'(row_drv), 32'(exp_row));
    endtask

    // Change a row's keys just after a frame starts, optionally queueing the write
    task automatic key_event(input int r, input logic [7:0] v, input bit push,
                             input logic [7:0] d, input bit lat);
        wait_frame();
        @(posedge ph1);
        #1;
        keys[r] = v;
        if (push)
            q.push_back('{addr: 3'(r), data: d, stamp: frames, lat: lat});
    endtask

    task automatic drain();
        int n = 0;
        repeat (130) @(negedge ph1);
        while (q.size() != 0 && n < 300) begin
            @(negedge ph1);
            n++;
        end
        check("sb_drain", 32'(q.size()), 32'd0);
    endtask

    // Global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic [7:0] exp_row;
        for (int r = 0; r < 8; r++)
            keys[r] = 8'h00;

        // Reset held with scan_en=1
        repeat (3) @(negedge ph1);
        check("rst_row_drv",    32'(row_drv),    32'd0);
        check("rst_wr_req",     32'(wr_req),     32'd0);
        check("rst_wr_addr",    32'(wr_addr),    32'd0);
        check("rst_wr_data",    32'(wr_data),    32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge ph1);
        #1;
        reset = 1'b1;

        // Scan order, break-before-make gaps and frame period
        wait_row(8'h01);
        for (int c = 0; c <= 48; c++) begin
            int m;
            if (c > 0)
                @(negedge ph1);
            m       = c % 24;
            exp_row = (m % 3 == 2) ? 8'h00 : 8'(1 << (m / 3));
            check("scan_row_drv", 32'(row_drv), 32'(exp_row));
            check("scan_frame_done", 32'(frame_done), (c == 24 || c == 48) ? 32'd1 : 32'd0);
        end

        // Level press / release, row 2 col 5, ack tied high
        key_event(2, 8'h20, 1'b1, 8'h20, 1'b1);
        drain();
        key_event(2, 8'h00, !TOGGLE, 8'h00, 1'b1);
        drain();

        // Bouncing row 5, then steady press
        for (int f = 0; f < 6; f++)
            key_event(5, (f % 2 == 0) ? 8'h01 : 8'h00, 1'b0, 8'h00, 1'b0);
        key_event(5, 8'h01, 1'b1, 8'h01, 1'b1);
        drain();
        key_event(5, 8'h00, !TOGGLE, 8'h00, 1'b1);
        drain();

        // Handshake stall on row 1
        @(posedge ph1);
        #1;
        wr_ack = 1'b0;
        key_event(1, 8'h80, 1'b1, 8'h80, 1'b0);
        wait_wr_req();
        for (int i = 0; i < 7; i++) begin
            if (i > 0)
                @(negedge ph1);
            check("hs_wr_req",  32'(wr_req),  32'd1);
            check("hs_wr_addr", 32'(wr_addr), 32'd1);
            check("hs_wr_data", 32'(wr_data), 32'h80);
            check("hs_row_drv", 32'(row_drv), 32'd0);
        end
        @(posedge ph1);
        #1;
        wr_ack = 1'b1;
        @(negedge ph1);
        check("hs_req_before_ack_edge", 32'(wr_req), 32'd1);
        @(negedge ph1);
        check("hs_req_after_ack",  32'(wr_req),  32'd0);
        check("hs_resume_row",     32'(row_drv), 32'h04);
        @(posedge ph1);
        #1;
        wr_ack = 1'b0;

        // scan_en drops during WRITE on row 3
        key_event(3, 8'h0F, 1'b1, 8'h0F, 1'b0);
        wait_wr_req();
        @(posedge ph1);
        #1;
        scan_en = 1'b0;
        @(posedge ph1);
        #1;
        wr_ack = 1'b1;
        @(negedge ph1);
        @(negedge ph1);
        check("stop_wr_req",  32'(wr_req),  32'd0);
        check("stop_row_drv", 32'(row_drv), 32'd0);
        repeat (4) begin
            @(negedge ph1);
            check("stop_idle_row_drv", 32'(row_drv),    32'd0);
            check("stop_idle_frame",   32'(frame_done), 32'd0);
        end
        @(posedge ph1);
        #1;
        wr_ack  = 1'b0;
        scan_en = 1'b1;
        wait_row(8'h10);

        // Reset asserted during WRITE on row 6
        key_event(6, 8'h42, 1'b1, 8'h42, 1'b0);
        wait_wr_req();
        #2;
        reset = 1'b0;
        for (int r = 0; r < 8; r++)
            keys[r] = 8'h00;
        q.delete(q.size() - 1);
        #1;
        check("rst_mid_wr_req",  32'(wr_req),  32'd0);
        check("rst_mid_row_drv", 32'(row_drv), 32'd0);
        check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_mid_wr_data", 32'(wr_data), 32'd0);
        repeat (3) @(posedge ph1);
        #1;
        reset  = 1'b1;
        wr_ack = 1'b1;
        wait_row(8'h01);
        drain();

        // Row 0 col 3: press, release, press
        key_event(0, 8'h08, 1'b1, 8'h08, 1'b1);
        drain();
        key_event(0, 8'h00, !TOGGLE, 8'h00, 1'b1);
        drain();
        key_event(0, 8'h08, 1'b1, TOGGLE ? 8'h00 : 8'h08, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
